// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        ADD1 = 3'd1,
        ADD2 = 3'd2,
        SUB1 = 3'd3,
        SUB2 = 3'd4
    } recode_op_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps the multiplier triplet {q1, q0, q_m1} to a partial-product op.
module booth_recode
    import mult_pkg::*;
(
    input  logic [2:0]  triplet_i,
    output recode_op_t  op_o
);

    always_comb begin
        op_o = ZERO;
        case (triplet_i)
            3'b001, 3'b010: op_o = ADD1;
            3'b011:         op_o = ADD2;
            3'b100:         op_o = SUB2;
            3'b101, 3'b110: op_o = SUB1;
            default:        op_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier, two multiplier bits per RUN cycle.
// Optional signed-overflow flag on data_exception is built only when MULT_OVERFLOW_EN is defined.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | WIDTH/2 add-and-shift steps
// DONE  | one-cycle data_resultRDY pulse, result registered
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2 - 1);

    mult_state_t      state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic [WIDTH-1:0] result_q;
    logic             rdy_q;
    logic             busy_q;

    logic [AW-1:0]    a_ext;
    logic [AW-1:0]    addend;
    logic             cin;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    acc_d;
    logic [WIDTH-1:0] q_d;
    logic             qm1_d;
    recode_op_t       op;

    booth_recode u_recode (
        .triplet_i ({q_q[1:0], qm1_q}),
        .op_o      (op)
    );

    // Subtraction is add of the inverted operand with carry-in; then shift the whole register by 2.
    always_comb begin
        a_ext  = {{2{a_q[WIDTH-1]}}, a_q};
        addend = '0;
        cin    = 1'b0;
        case (op)
            ADD1: addend = a_ext;
            ADD2: addend = a_ext << 1;
            SUB1: begin
                addend = ~a_ext;
                cin    = 1'b1;
            end
            SUB2: begin
                addend = ~(a_ext << 1);
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        sum   = acc_q + addend + {{(AW-1){1'b0}}, cin};
        acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[WIDTH-1:2]};
        qm1_d = q_q[1];
    end

`ifdef MULT_OVERFLOW_EN
    logic exc_q;
    logic exc_d;
    assign exc_d          = (acc_d[WIDTH-1:0] != {WIDTH{q_d[WIDTH-1]}});
    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULT_OVERFLOW_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT) begin
                a_q     <= data_operandA;
                acc_q   <= '0;
                q_q     <= data_operandB;
                qm1_q   <= 1'b0;
                cnt_q   <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            rdy_q    <= 1'b1;
                            result_q <= q_d;
`ifdef MULT_OVERFLOW_EN
                            exc_q    <= exc_d;
`endif
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=32) using an expected-result queue.
module tb_booth_mult_seq;

    localparam int W = 32;

    typedef struct packed {
        logic         exc;
        logic [W-1:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ctrl_MULT;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        exp_t e;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        e.res = p[W-1:0];
`ifdef MULT_OVERFLOW_EN
        e.exc = (p[2*W-1:W] != {W{p[W-1]}});
`else
        e.exc = 1'b0;
`endif
        return e;
    endfunction

    // Called one time unit after an edge; returns one time unit after the sampling edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk); #1;
        ctrl_MULT = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (3) tick();
        checks++;
        if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got res=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b want 0 0", data_resultRDY, busy);
        end
    endtask

    task automatic test_basic_timing();
        exp_t e;
        int   bad_rdy  = 0;
        int   bad_busy = 0;
        sb.push_back(model(32'd3, 32'd4));
        start_op(32'd3, 32'd4);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got %b want 1", busy);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (data_resultRDY !== (k == 16)) bad_rdy++;
            if (busy !== (k < 16)) bad_busy++;
            if (k == 16 && data_resultRDY === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (data_result !== e.res || data_exception !== e.exc || e.res !== 32'd12) begin
                    failures++;
                    $display("FAIL basic_3x4 got res=%h exc=%b want res=%h exc=%b",
                             data_result, data_exception, e.res, e.exc);
                end
            end
        end
        checks++;
        if (bad_rdy != 0) begin
            failures++;
            $display("FAIL basic_rdy_timing got %0d wrong cycles want 0", bad_rdy);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL basic_busy_timing got %0d wrong cycles want 0", bad_busy);
        end
        checks++;
        if (data_result !== 32'd12) begin
            failures++;
            $display("FAIL basic_hold got res=%h want 0000000c", data_result);
        end
        sb.delete();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[$];
        logic [W-1:0] vb[$];
        exp_t e;
        bit   seen;
        va = '{32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h0001_2345};
        vb = '{32'd6,         32'd2,         32'hFFFF_FFFF, 32'd1,         32'h8000_0000,
               32'hFFFF_FFFF, 32'h0000_0000};
        for (int r = 0; r < 6; r++) begin
            va.push_back($urandom);
            vb.push_back($urandom);
        end
        for (int i = 0; i < va.size(); i++) begin
            sb.push_back(model(va[i], vb[i]));
            start_op(va[i], vb[i]);
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                tick();
                if (data_resultRDY === 1'b1) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    checks++;
                    if (data_result !== e.res || data_exception !== e.exc) begin
                        failures++;
                        $display("FAIL vector_%0d a=%h b=%h got res=%h exc=%b want res=%h exc=%b",
                                 i, va[i], vb[i], data_result, data_exception, e.res, e.exc);
                    end
                end
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL vector_%0d_timeout got no rdy want rdy", i);
                sb.delete();
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        start_op(32'd5, 32'd5);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got res=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (data_resultRDY !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_mid_no_rdy got %0d pulses want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   pulses = 0;
        start_op(32'd5, 32'd5);
        repeat (7) tick();
        sb.push_back(model(32'd9, 32'd9));
        start_op(32'd9, 32'd9);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (data_resultRDY === 1'b1) begin
                pulses++;
                checks++;
                if (k != 16) begin
                    failures++;
                    $display("FAIL b2b_rdy_cycle got %0d want 16", k);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (data_result !== e.res || e.res !== 32'd81) begin
                        failures++;
                        $display("FAIL b2b_result got %h want %h", data_result, e.res);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_pulse_count got %0d want 1", pulses);
        end
        sb.delete();
    endtask

    task automatic test_done_restart();
        exp_t e;
        bit   seen = 1'b0;
        int   k2   = 0;
        sb.push_back(model(32'd3, 32'd5));
        sb.push_back(model(32'd2, 32'hFFFF_FFF9));
        start_op(32'd3, 32'd5);
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_first_timeout got no rdy want rdy");
        end else begin
            e = sb.pop_front();
            if (data_result !== e.res) begin
                failures++;
                $display("FAIL done_first_result got %h want %h", data_result, e.res);
            end
        end
        start_op(32'd2, 32'hFFFF_FFF9);
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b1 || data_result !== 32'd15) begin
            failures++;
            $display("FAIL done_restart_state got rdy=%b busy=%b res=%h want 0 1 0000000f",
                     data_resultRDY, busy, data_result);
        end
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            if (data_resultRDY === 1'b1) begin
                seen = 1'b1;
                k2   = k;
            end
        end
        checks++;
        if (!seen || k2 != 16) begin
            failures++;
            $display("FAIL done_second_timing got cycle %0d want 16", k2);
        end else begin
            e = sb.pop_front();
            checks++;
            if (data_result !== e.res || data_exception !== e.exc) begin
                failures++;
                $display("FAIL done_second_result got res=%h exc=%b want res=%h exc=%b",
                         data_result, data_exception, e.res, e.exc);
            end
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_vectors();
        test_reset_mid();
        test_back_to_back();
        test_done_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width; even, at least 4.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: ctrl_MULT  input  1  start pulse; operands are sampled on the same edge.
REQ-005 SHALL have port: data_operandA  input  WIDTH  multiplicand, two's complement.
REQ-006 SHALL have port: data_operandB  input  WIDTH  multiplier, two's complement.
REQ-007 SHALL have port: data_result  output  WIDTH  low WIDTH bits of the product.
REQ-008 SHALL have port: data_exception  output  1  signed overflow of the WIDTH-bit result.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  output  1  high while in RUN.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL handle ctrl_MULT=1 in any state as follows: latch A and B, clear the accumulator, clear the cycle counter, and enter RUN.
REQ-013 SHALL hold a product register {acc[WIDTH+1:0], q[WIDTH-1:0], q_m1}, loaded at start with acc=0, q=B, q_m1=0.
REQ-014 SHALL, in each RUN cycle, recode triplet {q[1],q[0],q_m1}: 000/111 -> +0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-015 SHALL sign-extend A to WIDTH+2 bits for the add/subtract; subtraction is the add of the bitwise inverse with carry-in 1.
REQ-016 SHALL, after the add, arithmetic-shift the whole product register right by 2 in the same cycle.
REQ-017 SHALL perform exactly WIDTH/2 RUN cycles, then enter DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-018 SHALL assert data_resultRDY only in DONE; with ctrl_MULT sampled at edge 0, the pulse is high during cycle WIDTH/2+1 (cycle 17 for WIDTH=32).
REQ-019 SHALL register data_result = q[WIDTH-1:0] on entry to DONE and hold it until the next completion.
REQ-020 SHALL keep busy high from the edge after start until entry to DONE.
REQ-021 SHALL, when ctrl_MULT is asserted during RUN, abandon the current operation, emit no resultRDY for it, and restart with the new operands.
REQ-022 SHALL, when ctrl_MULT is asserted during DONE, still emit the resultRDY pulse and the old result, and begin the new operation.
REQ-023 SHALL produce correct results for operands equal to the most-negative value (e.g. 0x80000000).

Reset
REQ-024 SHALL, on reset, immediately force state=IDLE, busy=0, data_resultRDY=0, data_result=0, data_exception=0, counter=0 and the product register to 0.
REQ-025 SHALL discard any operation in progress at reset; no resultRDY SHALL follow until a new ctrl_MULT.

Configuration
REQ-026 SHALL, with MULT_OVERFLOW_EN defined, set data_exception in DONE when the upper product bits acc[WIDTH-1:0] are not all equal to q[WIDTH-1]; it SHALL be held with data_result.
REQ-027 SHALL, without MULT_OVERFLOW_EN, tie data_exception to 0 and synthesise no overflow logic.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/DONE), the recode-op enum (ZERO, ADD1, ADD2, SUB1, SUB2) and the default WIDTH constant in shared package mult_pkg.
REQ-029 SHALL use one combinational sub-module, booth_recode (triplet in, recode op out), instantiated once.

Verification
REQ-030 SHALL cover: A=3, B=4, start at edge 0 -> data_result=12, exception=0, resultRDY high only in cycle 17.
REQ-031 SHALL cover: A=-7, B=6 -> data_result=0xFFFFFFD6, exception=0.
REQ-032 SHALL cover: A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE; exception=1 with MULT_OVERFLOW_EN and 0 without.
REQ-033 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1 (with EN); and A=0x80000000, B=1 -> data_result=0x80000000, exception=0.
REQ-034 SHALL cover: start 5*5, reset at cycle 6 -> all outputs 0 at once and no resultRDY in the following 40 cycles.
REQ-035 SHALL cover: start 5*5, then start 9*9 at cycle 8 -> a single resultRDY 17 cycles after the second start, with data_result=81.
